// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU among NUM_REQ requesters.
// Latency: accept -> EXEC (1 cycle) -> RESP; response visible one edge after EXEC.
// Backpressure: RESP holds until rsp_ready; no new accept until the response is taken.

module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  opcode,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (opcode)
            3'b000:  result = a + b;
            3'b001:  result = a - b;
            3'b010:  result = a & b;
            3'b011:  result = a | b;
            3'b100:  result = a ^ b;
            3'b101:  result = a << b[4:0];
            3'b110:  result = a >> b[4:0];
            default: result = {31'd0, $signed(a) < $signed(b)};
        endcase
        zero = (result == '0);
    end

endmodule

module alu_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    input  logic [NUM_REQ*3-1:0]   req_opcode,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_result,
    output logic                   rsp_zero,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr, grant_id, next_ptr, cand;
    logic              grant_vld, accept;
    logic [31:0]       a_arr [NUM_REQ];
    logic [31:0]       b_arr [NUM_REQ];
    logic [2:0]        op_arr[NUM_REQ];
    logic [31:0]       op_a, op_b, alu_result;
    logic [2:0]        op_code;
    logic [ID_W-1:0]   op_id;
    logic              alu_zero;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_arr[i]  = req_a[32*i +: 32];
            b_arr[i]  = req_b[32*i +: 32];
            op_arr[i] = req_opcode[3*i +: 3];
        end
    end

    // Walk upward from rr_ptr with wrap; first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_id  = cand;
            end
            cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
        end
        next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_n so no grant is ever offered while reset is held.
                if (grant_vld && rst_n) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                    for (int i = 0; i < NUM_REQ; i++)
                        req_ready[i] = (grant_id == ID_W'(i));
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= '0;
            op_id      <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a    <= a_arr[grant_id];
                op_b    <= b_arr[grant_id];
                op_code <= op_arr[grant_id];
                op_id   <= grant_id;
                rr_ptr  <= next_ptr;
            end
            if (state_q == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_id     <= op_id;
            end
        end
    end

    alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .opcode (op_code),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, handshake corner sequences, randomized run vs reference model.
module tb_alu_arbiter;

    localparam int NR  = 4;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*32-1:0]  req_a, req_b;
    logic [NR*3-1:0]   req_opcode;
    logic              rsp_valid, rsp_ready, rsp_zero, busy;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [31:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << (b % 32);
            3'd6: r = a >> (b % 32);
            default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++)
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        req_a[32*r +: 32]    = a;
        req_b[32*r +: 32]    = b;
        req_opcode[3*r +: 3] = op;
    endtask

    task automatic do_reset;
        req_valid = '1;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("rst_busy",      32'(busy),       32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),  32'd0);
        chk("rst_req_ready", 32'(req_ready),  32'd0);
        chk("rst_rsp_id",    32'(rsp_id),     32'd0);
        chk("rst_result",    rsp_result,      32'd0);
        chk("rst_zero",      32'(rsp_zero),   32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
    endtask

    // Single transaction from requester r with rsp_ready held high; starts and ends at posedge+1.
    task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] eres, input logic ezero);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        set_req(r, a, b, op);
        rsp_ready = 1'b1;
        #1;
        chk("op_grant", 32'(req_ready), 32'(1 << r));
        @(posedge clk); #1;
        req_valid = '0;
        chk("op_exec_busy",  32'(busy),      32'd1);
        chk("op_exec_rsp",   32'(rsp_valid), 32'd0);
        chk("op_exec_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("op_rsp_valid",  32'(rsp_valid), 32'd1);
        chk("op_rsp_id",     32'(rsp_id),    32'(r));
        chk("op_rsp_result", rsp_result,     eres);
        chk("op_rsp_zero",   32'(rsp_zero),  32'(ezero));
        @(posedge clk); #1;
        chk("op_done_busy",  32'(busy),      32'd0);
        chk("op_done_rsp",   32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ptr, acc_c, e_id, g, nresp;
        bit          inflight, exp_rv;
        logic [31:0] e_res;
        logic        e_zero;

        vecs[0]  = '{0, 32'd5,          32'd7,          3'd0, 32'd12,         1'b0};
        vecs[1]  = '{2, 32'd9,          32'd9,          3'd1, 32'd0,          1'b1};
        vecs[2]  = '{1, 32'hF0F0_1234,  32'h0FF0_00FF,  3'd2, 32'h00F0_0034,  1'b0};
        vecs[3]  = '{3, 32'hA000_0000,  32'h0000_0005,  3'd3, 32'hA000_0005,  1'b0};
        vecs[4]  = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  3'd4, 32'd0,          1'b1};
        vecs[5]  = '{1, 32'd1,          32'd31,         3'd5, 32'h8000_0000,  1'b0};
        vecs[6]  = '{2, 32'h8000_0000,  32'd36,         3'd6, 32'h0800_0000,  1'b0};
        vecs[7]  = '{3, 32'hFFFF_FFFF,  32'd1,          3'd7, 32'd1,          1'b0};
        vecs[8]  = '{0, 32'd1,          32'hFFFF_FFFF,  3'd7, 32'd0,          1'b1};
        vecs[9]  = '{1, 32'hFFFF_FFFF,  32'd1,          3'd0, 32'd0,          1'b1};
        vecs[10] = '{2, 32'd3,          32'd5,          3'd1, 32'hFFFF_FFFE,  1'b0};

        rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_opcode = '0;
        #2;
        do_reset();

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_res, vecs[i].exp_zero);

        // Fairness with all requesters continuously asserted
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 32'(i * 10), 32'(i), 3'd0);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_grant", 32'(req_ready), 32'(1 << (k % NR)));
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("fair_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("fair_rsp_id",    32'(rsp_id),    32'(k % NR));
            chk("fair_result",    rsp_result,     32'(11 * (k % NR)));
            @(posedge clk);
        end
        #1;
        req_valid = '0;
        @(posedge clk); #1;

        // Backpressure: five cycles of rsp_ready low while in RESP
        req_valid = 4'b0001;
        set_req(0, 32'd40, 32'd2, 3'd0);
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 4'b1110;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_result",    rsp_result,     32'd42);
            chk("bp_rsp_id",    32'(rsp_id),    32'd0);
            chk("bp_busy",      32'(busy),      32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_last_valid", 32'(rsp_valid), 32'd1);
        chk("bp_last_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp_done_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_busy",  32'(busy),      32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        req_valid = '0;
        @(posedge clk); #1;

        // Operands change right after the accept
        req_valid = 4'b0010;
        set_req(1, 32'd100, 32'd23, 3'd0);
        rsp_ready = 1'b1;
        #1;
        chk("chg_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        set_req(1, 32'd999, 32'd1, 3'd1);
        req_valid = '0;
        @(posedge clk); #1;
        chk("chg_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("chg_rsp_id",    32'(rsp_id),    32'd1);
        chk("chg_result",    rsp_result,     32'd123);
        @(posedge clk); #1;

        // Reset pulsed during RESP
        do_reset();
        req_valid = 4'b0010;
        set_req(1, 32'd1, 32'd2, 3'd0);
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("mr_rsp_valid_pre", 32'(rsp_valid), 32'd1);
        req_valid = 4'b1010;
        rst_n = 1'b0;
        #1;
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_busy",      32'(busy),      32'd0);
        chk("mr_req_ready", 32'(req_ready), 32'd0);
        chk("mr_result",    rsp_result,     32'd0);
        #3;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        set_req(1, 32'd6, 32'd1, 3'd1);
        #1;
        chk("mr_first_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("mr_after_valid",  32'(rsp_valid), 32'd1);
        chk("mr_after_id",     32'(rsp_id),    32'd1);
        chk("mr_after_result", rsp_result,     32'd5);
        @(posedge clk); #1;

        // Reset during EXEC: the in-flight result must never surface
        req_valid = 4'b0100;
        set_req(2, 32'd3, 32'd4, 3'd0);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("rx_busy", 32'(busy), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("rx_no_ghost", 32'(rsp_valid), 32'd0);
        end

        // Randomized run against the transaction-level model
        do_reset();
        ptr = 0; inflight = 1'b0; acc_c = 0; e_id = 0; e_res = '0; e_zero = 1'b0; nresp = 0;
        for (int c = 0; c < 400; c++) begin
            req_valid = NR'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++)
                set_req(i, $urandom, ($urandom_range(0, 1) == 1) ? $urandom : req_a[32*i +: 32],
                        3'($urandom_range(0, 7)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rv = inflight && (c - acc_c >= 2);
            chk("rnd_busy",      32'(busy),      32'(inflight));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) begin
                chk("rnd_rsp_id",  32'(rsp_id),   32'(e_id));
                chk("rnd_result",  rsp_result,    e_res);
                chk("rnd_zero",    32'(rsp_zero), 32'(e_zero));
            end
            g = inflight ? -1 : rr_pick(req_valid, ptr);
            chk("rnd_req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
            if (g >= 0) begin
                inflight = 1'b1;
                acc_c    = c;
                e_id     = g;
                {e_zero, e_res} = ref_alu(req_a[32*g +: 32], req_b[32*g +: 32], req_opcode[3*g +: 3]);
                ptr = (g + 1) % NR;
            end else if (exp_rv && rsp_ready) begin
                inflight = 1'b0;
                nresp++;
            end
            @(posedge clk); #1;
        end
        chk("rnd_progress", 32'(nresp >= 20), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
